// File: rtl/ct_vfdsu_issue_wb_ctrl_pkg.sv
// Shared definitions for the VFDSU issue/writeback controller: tag widths,
// writeback slot delay and FSM state encodings.
package ct_vfdsu_issue_wb_ctrl_pkg;

  localparam int WB_SLOT_DLY = 2;
  localparam int IID_W       = 7;
  localparam int PREG_W      = 7;
  localparam int FFLAGS_W    = 5;
  localparam int DATA_W      = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_EX1   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CMPLT = 3'd4
  } div_state_e;

endpackage

// File: rtl/ct_vfdsu_issue_wb_ctrl_wb_rsv_sreg.sv
// Writeback slot reservation shift register: a divider wb_req enters bit 0 and
// walks up one bit per cycle until the result slot is reached.
module ct_vfdsu_wb_rsv_sreg
  import ct_vfdsu_issue_wb_ctrl_pkg::*;
#(
  parameter int N = WB_SLOT_DLY
) (
  input  logic forever_cpuclk,
  input  logic cpurst_b,
  input  logic wb_req,
  input  logic flush,
  output logic rsv_vld
);

  logic [N-1:0] sreg;
  logic         sreg_en;

  assign sreg_en = wb_req | (|sreg) | flush;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      sreg <= '0;
    end else if (sreg_en) begin
      if (flush) begin
        sreg <= '0;
      end else begin
        sreg <= {sreg[N-2:0], wb_req};
      end
    end
  end

  // Pipe-X sees the reservation one cycle ahead of the slot it protects.
  assign rsv_vld = sreg[N-2];

  a_wb_req_overlap: assert property (
    @(posedge forever_cpuclk) disable iff (!cpurst_b) !(wb_req && (|sreg))
  );

endmodule

// File: rtl/ct_vfdsu_issue_wb_ctrl.sv
// Dispatch-side controller for the VFDSU divider: issues one FDIV/FSQRT at a
// time, holds its tag while in flight and writes the result back to RTU/preg.
module ct_vfdsu_issue_wb_ctrl
  import ct_vfdsu_issue_wb_ctrl_pkg::*;
(
  input  logic                forever_cpuclk,
  input  logic                cpurst_b,
  input  logic                rtu_yy_xx_flush,
  input  logic                idu_div_issue_vld,
  input  logic [IID_W-1:0]    idu_div_issue_iid,
  input  logic [PREG_W-1:0]   idu_div_issue_preg,
  input  logic                idu_div_issue_gateclk,
  input  logic                vfdsu_dp_fdiv_busy,
  input  logic                vfdsu_dp_inst_wb_req,
  input  logic                pipex_dp_vfdsu_inst_vld,
  input  logic [DATA_W-1:0]   vfdsu_dp_result,
  input  logic [FFLAGS_W-1:0] vfdsu_dp_fflags,
  output logic                div_idu_issue_rdy,
  output logic                dp_vfdsu_idu_fdiv_issue,
  output logic                dp_vfdsu_fdiv_gateclk_issue,
  output logic                dp_vfdsu_ex1_pipex_sel,
  output logic                div_pipex_wb_rsv,
  output logic                div_rtu_cmplt_vld,
  output logic [IID_W-1:0]    div_rtu_cmplt_iid,
  output logic [FFLAGS_W-1:0] div_rtu_fflags,
  output logic                div_rf_wen,
  output logic [PREG_W-1:0]   div_rf_preg,
  output logic [DATA_W-1:0]   div_rf_data
);

  div_state_e          state, state_nxt;
  logic                fsm_en;
  logic                issue_acc;
  logic                tag_vld;
  logic [IID_W-1:0]    tag_iid;
  logic [PREG_W-1:0]   tag_preg;
  logic [DATA_W-1:0]   res_data;
  logic [FFLAGS_W-1:0] res_fflags;
  logic                cmplt;

  assign div_idu_issue_rdy           = (state == ST_IDLE) & ~vfdsu_dp_fdiv_busy;
  assign dp_vfdsu_idu_fdiv_issue     = idu_div_issue_vld & div_idu_issue_rdy;
  assign dp_vfdsu_fdiv_gateclk_issue = idu_div_issue_gateclk & div_idu_issue_rdy;
  assign issue_acc                   = dp_vfdsu_idu_fdiv_issue & ~rtu_yy_xx_flush;
  assign fsm_en = dp_vfdsu_fdiv_gateclk_issue | (state != ST_IDLE) | rtu_yy_xx_flush;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state <= ST_IDLE;
    end else if (fsm_en) begin
      state <= state_nxt;
    end
  end

  // Flush overrides every transition; a flushed issue never leaves IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (issue_acc) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_EX1;
      ST_EX1:   state_nxt = ST_WAIT;
      ST_WAIT:  if (pipex_dp_vfdsu_inst_vld) state_nxt = ST_CMPLT;
      ST_CMPLT: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (rtu_yy_xx_flush) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      tag_vld  <= 1'b0;
      tag_iid  <= '0;
      tag_preg <= '0;
    end else if (rtu_yy_xx_flush) begin
      tag_vld  <= 1'b0;
    end else if (issue_acc) begin
      tag_vld  <= 1'b1;
      tag_iid  <= idu_div_issue_iid;
      tag_preg <= idu_div_issue_preg;
    end else if (state == ST_CMPLT) begin
      tag_vld  <= 1'b0;
    end
  end

  // Result capture is enabled by inst_vld alone; stale captures are harmless
  // because the outputs are only exposed in CMPLT.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      res_data   <= '0;
      res_fflags <= '0;
    end else if (pipex_dp_vfdsu_inst_vld) begin
      res_data   <= vfdsu_dp_result;
      res_fflags <= vfdsu_dp_fflags;
    end
  end

  ct_vfdsu_wb_rsv_sreg #(.N(WB_SLOT_DLY)) u_wb_rsv_sreg (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .wb_req         (vfdsu_dp_inst_wb_req),
    .flush          (rtu_yy_xx_flush),
    .rsv_vld        (div_pipex_wb_rsv)
  );

  assign cmplt                  = (state == ST_CMPLT) & tag_vld;
  assign dp_vfdsu_ex1_pipex_sel = (state == ST_EX1);
  assign div_rtu_cmplt_vld      = cmplt;
  assign div_rf_wen             = cmplt;
  assign div_rtu_cmplt_iid      = cmplt ? tag_iid    : '0;
  assign div_rf_preg            = cmplt ? tag_preg   : '0;
  assign div_rf_data            = cmplt ? res_data   : '0;
  assign div_rtu_fflags         = cmplt ? res_fflags : '0;

endmodule
